// File: rtl/encoder_fec_pkg.sv
// Shared encoder datapath constants and types.
// Holds the FIFO threshold defaults and the level-width helper.
package encoder_fec_pkg;

  localparam int unsigned DATA_WIDTH      = 8;
  localparam int unsigned ENTRIES_BUFFER  = 16;
  localparam int unsigned HALF_CLK_PERIOD = 5;

  localparam int unsigned FIFO_AF_DEFAULT = 12;
  localparam int unsigned FIFO_AE_DEFAULT = 3;

  typedef logic [DATA_WIDTH-1:0] message_data_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  // Width needed to hold an occupancy of 0..entries inclusive.
  function automatic int unsigned fifo_lw(input int unsigned entries);
    return $clog2(entries + 1);
  endfunction

endpackage

// File: rtl/fifo_flags_if.sv
// Handshake, data, threshold and status bundle of fifo_flags.
// The master is the user of the FIFO; the slave is the FIFO itself.
interface fifo_flags_if
  import encoder_fec_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_WIDTH,
  parameter int unsigned ENTRIES = ENTRIES_BUFFER
);
  localparam int unsigned LW = fifo_lw(ENTRIES);

  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             almost_empty;
  logic [LW-1:0]    level;
  logic [LW-1:0]    af_level;
  logic [LW-1:0]    ae_level;
  logic             overflow;
  logic             underflow;
  logic             clr_err;

  modport master (
    output wr_en, data_in, rd_en, af_level, ae_level, clr_err,
    input  data_out, rd_valid, empty, full, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, af_level, ae_level, clr_err,
    output data_out, rd_valid, empty, full, almost_full, almost_empty,
           level, overflow, underflow
  );

endinterface

// File: rtl/fifo_flags_ptr.sv
// Wrapping pointer counter for arbitrary depth: counts 0..ENTRIES-1, then
// returns to 0 explicitly.
module fifo_flags_ptr #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned PW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(ENTRIES - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fifo_flags.sv
// Synchronous FIFO with arbitrary depth, optional first-word-fall-through,
// occupancy level, programmable almost-full/empty and sticky error flags.
module fifo_flags
  import encoder_fec_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_WIDTH,
  parameter int unsigned ENTRIES = ENTRIES_BUFFER,
  parameter int unsigned FWFT    = 0
) (
  input  logic         clk,
  input  logic         rst,
  fifo_flags_if.slave  bus
);

  localparam int unsigned LW = fifo_lw(ENTRIES);
  localparam int unsigned PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  fifo_err_t        err_q;

  logic empty_c;
  logic full_c;
  logic rd_acc_c;
  logic wr_acc_c;

  // A write into a full FIFO is only taken when a pop frees a slot this cycle.
  assign empty_c  = (level_q == '0);
  assign full_c   = (level_q == LW'(ENTRIES));
  assign rd_acc_c = bus.rd_en & ~empty_c;
  assign wr_acc_c = bus.wr_en & (~full_c | rd_acc_c);

  fifo_flags_ptr #(.ENTRIES(ENTRIES), .PW(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc_c),
    .ptr (wr_ptr)
  );

  fifo_flags_ptr #(.ENTRIES(ENTRIES), .PW(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc_c),
    .ptr (rd_ptr)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c && !rst) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
    end else if (wr_acc_c && !rd_acc_c) begin
      level_q <= level_q + LW'(1);
    end else if (rd_acc_c && !wr_acc_c) begin
      level_q <= level_q - LW'(1);
    end
  end

  // Sticky errors; a new event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q.overflow  <= (bus.wr_en & ~wr_acc_c) | (err_q.overflow & ~bus.clr_err);
      err_q.underflow <= (bus.rd_en & empty_c) | (err_q.underflow & ~bus.clr_err);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = mem[rd_ptr];
      assign bus.rd_valid = ~empty_c;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;
      logic             rv_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '0;
          rv_q   <= 1'b0;
        end else begin
          rv_q <= rd_acc_c;
          if (rd_acc_c) begin
            dout_q <= mem[rd_ptr];
          end
        end
      end

      assign bus.data_out = dout_q;
      assign bus.rd_valid = rv_q;
    end
  endgenerate

  assign bus.level        = level_q;
  assign bus.empty        = empty_c;
  assign bus.full         = full_c;
  assign bus.almost_full  = (level_q >= bus.af_level);
  assign bus.almost_empty = (level_q <= bus.ae_level);
  assign bus.overflow     = err_q.overflow;
  assign bus.underflow    = err_q.underflow;

endmodule

// File: doc/fifo_flags.md
# fifo_flags

Parametrised synchronous FIFO, next generation of the encoder datapath buffer. Adds:
- arbitrary (non-power-of-two) depth;
- a first-word-fall-through (FWFT) read mode;
- an occupancy count with runtime-programmable almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags.

It sits between the message source and the FEC encoder core and replaces the plain FIFO wherever back-pressure thresholds or error reporting are needed.

## Interface
- WIDTH, DATA_WIDTH: data word width in bits.
- ENTRIES, ENTRIES_BUFFER: depth in words, any value ≥ 2.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- LW, $clog2(ENTRIES+1): width of level and threshold ports (derived, not overridden).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- wr_en  in  1  write request.
- data_in  in  WIDTH  write data.
- rd_en  in  1  read (pop) request.
- data_out  out  WIDTH  read data.
- rd_valid  out  1  data_out holds a valid popped/head word.
- empty  out  1  level == 0.
- full  out  1  level == ENTRIES.
- almost_full  out  1  level ≥ af_level.
- almost_empty  out  1  level ≤ ae_level.
- level  out  LW  current occupancy, 0..ENTRIES.
- af_level  in  LW  almost-full threshold, sampled every cycle.
- ae_level  in  LW  almost-empty threshold, sampled every cycle.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was refused.
- clr_err  in  1  clears overflow/underflow.

## Operation
- Request acceptance:
  - rd_acc = rd_en & ~empty.
  - wr_acc = wr_en & (~full | rd_acc). A write is accepted when full only if a read is accepted in the same cycle.
- Storage: memory of ENTRIES×WIDTH. wr_ptr/rd_ptr count 0..ENTRIES-1 and wrap explicitly from ENTRIES-1 to 0. No modulo-2^n assumption.
- level next value:
  - +1 on wr_acc only;
  - −1 on rd_acc only;
  - unchanged on both or neither.
- empty, full, almost_full and almost_empty are combinational compares of the registered level. Thresholds are unsigned:
  - af_level = 0 forces almost_full = 1;
  - ae_level ≥ ENTRIES forces almost_empty = 1.
- Empty FIFO with wr_en and rd_en together: write accepted, read refused (underflow). There is no bypass.
- FWFT=0: on rd_acc, data_out ← mem[rd_ptr] and rd_valid = 1 in the next cycle. Otherwise rd_valid = 0 and data_out holds its last value.
- FWFT=1: data_out = mem[rd_ptr] (combinational read of the head) and rd_valid = ~empty. rd_acc advances the head, so the next word appears the following cycle.
- Errors:
  - overflow sets on wr_en & ~wr_acc;
  - underflow sets on rd_en & empty;
  - both hold until clr_err;
  - a set event in the same cycle as clr_err wins (flag remains 1).
- Reset values:
  - level 0, empty 1, full 0, almost_full = (af_level == 0), almost_empty 1;
  - rd_valid 0, data_out 0, overflow 0, underflow 0, pointers 0;
  - memory contents are not reset.
- Reset mid-operation: all contents are discarded. A read accepted in the reset cycle produces no rd_valid.

## Timing
- Write to empty: empty deasserts one cycle after the wr_acc edge. A read can then be accepted.
  - FWFT=0: rd_valid rises one cycle after that, so first-data latency is 2 cycles.
  - FWFT=1: data_out/rd_valid are valid 1 cycle after the write.
- Flags and level update one cycle after the accepting edge. Threshold port changes affect almost_* in the same cycle (combinational).
- Full with wr_en and rd_en together: both accepted, level stays at ENTRIES, full stays 1.
- Sustained throughput: one write and one read per cycle.

## Structure
- encoder_fec_pkg owns DATA_WIDTH, ENTRIES_BUFFER, message_data_t and HALF_CLK_PERIOD. Add FIFO_AF_DEFAULT and FIFO_AE_DEFAULT threshold constants there.
- One natural sub-module, fifo_flags_ptr: a wrapping pointer counter parametrised by ENTRIES, instantiated for wr_ptr and rd_ptr.
- Memory is inferred in the top module.

## Test plan
- ENTRIES=16, WIDTH=8, FWFT=0: write 0x00..0x0F, then read 16 words → data_out 0x00..0x0F in order, rd_valid one cycle after each rd_en. full=1 at level 16; empty=1 after the last read.
- ENTRIES=5: three rounds of write 5 / read 5 (values 1..15) → order preserved across pointer wrap. level never exceeds 5.
- Full FIFO with wr_en=rd_en=1 for 4 cycles → level stays 16, overflow=0, output order is correct. Then wr_en alone while full → overflow=1, level 16. Then clr_err → overflow=0 next cycle.
- Empty FIFO, rd_en=1 → underflow=1, rd_valid=0. Empty FIFO with wr_en=rd_en=1 (data 0xA5) → level 1, underflow=1.
- af_level=12, ae_level=3: fill 0→16 → almost_empty high for level ≤3, almost_full high from level 12. Change af_level to 14 at level 13 → almost_full drops the same cycle.
- FWFT=1: write 0x11, 0x22 → data_out=0x11 and rd_valid=1 one cycle after the first write. Pop → 0x22 next cycle. Assert rst at level 2 → level 0, empty 1, rd_valid 0 next cycle.
